// File: rtl/note_sequencer.sv
// note_sequencer: tempo-driven eight-note melody stepper with articulation gate and beat strobe
module note_sequencer #(
  parameter int TEMPO_CNT  = 25000000,
  parameter int TEMPO_BITS = 25,
  parameter int GAP_CNT    = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       stop,
  input  logic       step,
  input  logic [1:0] mode,
  output logic [2:0] note_sel,
  output logic       gate,
  output logic       beat,
  output logic       dir
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
  localparam logic [TEMPO_BITS-1:0] LAST = TEMPO_BITS'(TEMPO_CNT - 1);
  localparam logic [TEMPO_BITS-1:0] OPEN = TEMPO_BITS'(TEMPO_CNT - GAP_CNT);
  state_t                state_q;
  logic [TEMPO_BITS-1:0] cnt_q;
  logic [2:0]            note_q, note_d;
  logic                  dir_q, dir_d, beat_q, turn, up;
  // ping-pong climbs when dir is up and not at the top, or when down and at the bottom
  always_comb begin
    turn   = dir_q ? (note_q == 3'd0) : (note_q == 3'd7);
    up     = (mode == 2'b01) || ((mode == 2'b11) && (dir_q == turn));
    note_d = (mode == 2'b00) ? note_q : (up ? note_q + 3'd1 : note_q - 3'd1);
    dir_d  = (mode == 2'b00) ? dir_q : !up;
  end
  always_ff @(posedge clk) begin
    if (!reset || stop) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      note_q  <= '0;
      dir_q   <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      case (state_q)
        IDLE: if (play) begin
          state_q <= PLAY;
          cnt_q   <= '0;
          beat_q  <= 1'b1;
        end
        PLAY: if (!play) state_q <= PAUSE;
        else if (cnt_q == LAST) begin
          cnt_q  <= '0;
          note_q <= note_d;
          dir_q  <= dir_d;
          beat_q <= 1'b1;
        end else cnt_q <= cnt_q + TEMPO_BITS'(1);
        PAUSE: if (play) state_q <= PLAY;
        else if (step) begin
          cnt_q  <= '0;
          note_q <= note_d;
          dir_q  <= dir_d;
          beat_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign note_sel = note_q;
  assign dir      = dir_q;
  assign beat     = beat_q;
  assign gate     = (state_q == PLAY) && (cnt_q < OPEN);
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus random stimulus checked against a behavioural model
module tb_note_sequencer;
  localparam int TC = 10, GAP = 2;
  logic clk = 1'b0, reset = 1'b0, play = 1'b0, stop = 1'b0, step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] note_sel;
  logic gate, beat, dir;
  int checks = 0, failures = 0;
  bit on = 1'b0;
  int m_st = 0, m_cnt = 0, m_note = 0;
  bit m_dir = 1'b0, m_beat = 1'b0;
  int pp[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int n, g, keep;

  note_sequencer #(.TEMPO_CNT(TC), .TEMPO_BITS(4), .GAP_CNT(GAP)) dut (
    .clk(clk), .reset(reset), .play(play), .stop(stop), .step(step), .mode(mode),
    .note_sel(note_sel), .gate(gate), .beat(beat), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: st 0 idle, 1 play, 2 pause
  function automatic void advance();
    case (mode)
      2'b01: begin m_note = (m_note + 1) % 8; m_dir = 1'b0; end
      2'b10: begin m_note = (m_note + 7) % 8; m_dir = 1'b1; end
      2'b11: if (!m_dir) begin
        if (m_note == 7) begin m_note = 6; m_dir = 1'b1; end else m_note = m_note + 1;
      end else begin
        if (m_note == 0) begin m_note = 1; m_dir = 1'b0; end else m_note = m_note - 1;
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    m_beat = 1'b0;
    if (!reset || stop) begin
      m_st = 0; m_cnt = 0; m_note = 0; m_dir = 1'b0;
    end else if (m_st == 0) begin
      if (play) begin m_st = 1; m_cnt = 0; m_beat = 1'b1; end
    end else if (m_st == 1) begin
      if (!play) m_st = 2;
      else if (m_cnt == TC - 1) begin m_cnt = 0; advance(); m_beat = 1'b1; end
      else m_cnt = m_cnt + 1;
    end else begin
      if (play) m_st = 1;
      else if (step) begin advance(); m_cnt = 0; m_beat = 1'b1; end
    end
  end

  always @(negedge clk) if (on) begin
    chk("note_sel", note_sel, m_note);
    chk("gate", gate, (m_st == 1 && m_cnt < TC - GAP) ? 1 : 0);
    chk("beat", beat, m_beat);
    chk("dir", dir, m_dir);
  end

  // count cycles until the next beat, and gate-high cycles along the way
  task automatic nb(output int cyc, output int hi);
    cyc = 0; hi = 0;
    do begin
      if (gate) hi++;
      @(negedge clk);
      cyc++;
    end while (!beat && cyc < 40);
    if (cyc >= 40) chk("beat_timeout", cyc, 10);
  endtask

  initial begin
    play = 1'b1; mode = 2'b01;
    @(posedge clk); on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_note", note_sel, 0); chk("rst_gate", gate, 0);
      chk("rst_beat", beat, 0); chk("rst_dir", dir, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("start_beat", beat, 1); chk("start_note", note_sel, 0);
    for (int i = 0; i < 8; i++) begin
      nb(n, g);
      chk("asc_period", n, 10); chk("asc_gate_hi", g, 8); chk("asc_note", note_sel, (i + 1) % 8);
    end
    // pause mid-note, then single step
    for (int k = 0; k < 100 && !(m_note == 3 && m_cnt == 4); k++) @(negedge clk);
    chk("reach_n3c4", (m_note == 3 && m_cnt == 4) ? 1 : 0, 1);
    play = 1'b0;
    @(negedge clk);
    chk("pause_gate", gate, 0); chk("pause_note", note_sel, 3);
    repeat (3) @(negedge clk);
    chk("pause_hold", note_sel, 3);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk("step_note", note_sel, 4); chk("step_beat", beat, 1); chk("step_cnt", m_cnt, 0);
    play = 1'b1;
    @(negedge clk);
    nb(n, g);
    chk("resume_period", n, 10); chk("resume_gate_hi", g, 8); chk("resume_note", note_sel, 5);
    // stop on note 5
    stop = 1'b1;
    @(negedge clk);
    chk("stop_note", note_sel, 0); chk("stop_gate", gate, 0);
    chk("stop_dir", dir, 0); chk("stop_beat", beat, 0);
    repeat (2) begin
      @(negedge clk);
      chk("stop_play_gate", gate, 0); chk("stop_play_beat", beat, 0);
    end
    stop = 1'b0;
    repeat (5) @(negedge clk);
    play = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst2_note", note_sel, 0); chk("rst2_gate", gate, 0);
      chk("rst2_beat", beat, 0); chk("rst2_dir", dir, 0);
    end
    reset = 1'b1;
    // descend then hold
    mode = 2'b10; play = 1'b1;
    @(negedge clk);
    chk("desc_start", beat, 1);
    nb(n, g); chk("desc_n1", note_sel, 7); chk("desc_d1", dir, 1);
    nb(n, g); chk("desc_n2", note_sel, 6);
    mode = 2'b00;
    repeat (2) begin
      nb(n, g);
      chk("hold_period", n, 10); chk("hold_beat", beat, 1); chk("hold_note", note_sel, 6);
    end
    // ping-pong from IDLE
    stop = 1'b1; @(negedge clk); stop = 1'b0; mode = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      nb(n, g);
      chk("pp_note", note_sel, pp[i]); chk("pp_dir", dir, (i >= 7 && i <= 13) ? 1 : 0);
    end
    // play falls exactly on the last tempo cycle
    for (int k = 0; k < 40 && !(m_st == 1 && m_cnt == TC - 1); k++) @(negedge clk);
    keep = note_sel;
    play = 1'b0;
    @(negedge clk);
    chk("edge_pause_note", note_sel, keep); chk("edge_pause_beat", beat, 0);
    chk("edge_cnt", m_cnt, TC - 1);
    play = 1'b1;
    @(negedge clk); chk("edge_resume_nobeat", beat, 0);
    @(negedge clk); chk("edge_resume_beat", beat, 1);
    // random soak
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom % 300) != 0;
      stop  = ($urandom % 120) == 0;
      step  = ($urandom % 6) == 0;
      if ($urandom % 25 == 0) play = !play;
      if ($urandom % 50 == 0) mode = 2'($urandom);
    end
    @(negedge clk);
    on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
